// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared cell, status, direction and FSM state types for the win scanner
package tictactoe_pkg;

    typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10, RSVD = 2'b11} cell_t;
    typedef enum logic [1:0] {NONE = 2'b00, P1_WIN = 2'b01, P2_WIN = 2'b10, TIE = 2'b11} status_t;
    typedef enum logic [1:0] {ROW = 2'b00, COL = 2'b01, DIAG = 2'b10, ADIAG = 2'b11} dir_t;
    typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, DONE = 2'b10} state_t;

endpackage

// File: rtl/win_scanner_run_check.sv
// rtl/win_scanner_run_check.sv - combinational K-run check from one start cell in one direction
module run_check
    import tictactoe_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3,
    localparam int CELLS = N * N,
    localparam int IW = $clog2(CELLS)
) (
    input  logic [2*CELLS-1:0] snap,
    input  logic [IW-1:0]      idx,
    input  dir_t               dir,
    output logic               valid,
    output logic [1:0]         owner
);

    int         start;
    int         r;
    int         c;
    int         dr;
    int         dc;
    int         pos;
    logic       on;
    logic       ok;
    logic [1:0] first;

    always_comb begin
        start = (int'(idx) < CELLS) ? int'(idx) : 0;
        r     = start / N;
        c     = start % N;
        dr    = 0;
        dc    = 0;
        case (dir)
            ROW:     begin dr = 0; dc = 1;  end
            COL:     begin dr = 1; dc = 0;  end
            DIAG:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        // the run's far end must land on the board, otherwise the direction is void
        on    = (r + (K - 1) * dr < N) && (c + (K - 1) * dc >= 0) && (c + (K - 1) * dc < N);
        first = snap[2*start +: 2];
        ok    = on && (first == P1 || first == P2);
        pos   = 0;
        for (int k = 1; k < K; k++) begin
            pos = on ? (r + k * dr) * N + (c + k * dc) : 0;
            if (snap[2*pos +: 2] != first) ok = 1'b0;
        end
        valid = ok;
        owner = ok ? first : EMPTY;
    end

endmodule

// File: rtl/win_scanner.sv
// rtl/win_scanner.sv - sequential N x N, K-in-a-row win/tie scanner, one cell per cycle
module win_scanner
    import tictactoe_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3,
    localparam int CELLS = N * N,
    localparam int IW = $clog2(CELLS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*CELLS-1:0] board,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [IW-1:0]      win_cell,
    output logic [1:0]         win_dir
);

    state_t             state;
    logic [2*CELLS-1:0] snap;
    logic [IW-1:0]      idx;
    logic               full_acc;

    logic [3:0]         rc_valid;
    logic [1:0]         rc_owner [4];
    logic               hit;
    logic [1:0]         hit_dir;
    logic [1:0]         hit_owner;
    logic [1:0]         cur_cell;
    logic               cell_full;

    for (genvar d = 0; d < 4; d++) begin : g_dir
        run_check #(.N(N), .K(K)) u_run_check (
            .snap  (snap),
            .idx   (idx),
            .dir   (dir_t'(2'(d))),
            .valid (rc_valid[d]),
            .owner (rc_owner[d])
        );
    end

    // lowest direction code wins when several runs start at the same cell
    always_comb begin
        hit       = 1'b0;
        hit_dir   = 2'b00;
        hit_owner = 2'b00;
        for (int d = 3; d >= 0; d--) begin
            if (rc_valid[d]) begin
                hit       = 1'b1;
                hit_dir   = 2'(d);
                hit_owner = rc_owner[d];
            end
        end
    end

    assign cur_cell  = snap[2*int'(idx) +: 2];
    assign cell_full = (cur_cell == P1) || (cur_cell == P2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            snap     <= '0;
            idx      <= '0;
            full_acc <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            status   <= NONE;
            win_cell <= '0;
            win_dir  <= ROW;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SCAN;
                        snap     <= board;
                        idx      <= '0;
                        full_acc <= 1'b1;
                        busy     <= 1'b1;
                        status   <= NONE;
                        win_cell <= '0;
                        win_dir  <= ROW;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        status   <= (hit_owner == P1) ? P1_WIN : P2_WIN;
                        win_cell <= idx;
                        win_dir  <= hit_dir;
                    end else if (idx == IW'(CELLS - 1)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        status <= (full_acc && cell_full) ? TIE : NONE;
                    end else begin
                        idx      <= idx + 1'b1;
                        full_acc <= full_acc & cell_full;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
